// File: rtl/xor_descrambler.sv
// Self-synchronizing multiplicative descrambler: received scrambled bits feed the shift register,
// so the descrambler locks onto any scrambler state after LFSR_LEN bits.
module xor_descrambler #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LFSR_LEN = 7,
    parameter int unsigned TAP      = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_locked
);

    localparam int unsigned BcWidth = $clog2(LFSR_LEN + 1);
    localparam logic [BcWidth-1:0] BcFull = BcWidth'(LFSR_LEN);

    logic [LFSR_LEN-1:0] r_state;
    logic [LFSR_LEN-1:0] w_state_next;
    logic [BcWidth-1:0]  r_bc;
    logic [BcWidth-1:0]  w_bc_next;
    logic [31:0]         w_bc_sum;
    logic [WIDTH-1:0]    r_out_data;
    logic [WIDTH-1:0]    w_out_data_next;
    logic                r_out_valid;
    logic                r_locked;
    logic                w_accept;

    // Ready never looks at i_in_valid, so upstream may wait on it without a loop.
    assign o_in_ready = !i_flush && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;

    // Bit-serial recurrence unrolled across the word; bit 0 is oldest on the line.
    always_comb begin : descramble
        logic [LFSR_LEN-1:0] v_s;
        v_s             = r_state;
        w_out_data_next = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_out_data_next[i] = i_in_data[i] ^ v_s[TAP-1] ^ v_s[LFSR_LEN-1];
            v_s                = {v_s[LFSR_LEN-2:0], i_in_data[i]};
        end
        w_state_next = v_s;
    end

    assign w_bc_sum  = 32'(r_bc) + WIDTH;
    assign w_bc_next = (w_bc_sum >= LFSR_LEN) ? BcFull : BcWidth'(w_bc_sum);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= '0;
            r_bc     <= '0;
            r_locked <= 1'b0;
        end else if (i_flush) begin
            r_state  <= '0;
            r_bc     <= '0;
            r_locked <= 1'b0;
        end else if (w_accept) begin
            r_state  <= w_state_next;
            r_bc     <= w_bc_next;
            r_locked <= (w_bc_next == BcFull);
        end
    end

    // Output stage is untouched by flush so a pending word still drains.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_out_data_next;
            r_out_valid <= 1'b1;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_locked    = r_locked;

endmodule

// File: tb/tb_xor_descrambler.sv
// Bench for xor_descrambler: three lanes (WIDTH 8, 1, 3) checked every cycle against a
// bit-history model, plus hand-computed literals and a scrambler loopback.
module tb_xor_descrambler;

    localparam int L  = 7;
    localparam int T  = 6;
    localparam int NL = 3;

    localparam logic [3:0] MD = 4'b0001;
    localparam logic [3:0] MV = 4'b0010;
    localparam logic [3:0] ML = 4'b0100;
    localparam logic [3:0] MR = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [7:0]    in_data  [NL];
    logic [7:0]    out_data [NL];
    logic [NL-1:0] in_ready;
    logic [NL-1:0] out_valid;
    logic [NL-1:0] locked;

    logic [7:0] od0;
    logic [0:0] id1, od1;
    logic [2:0] id2, od2;

    assign id1         = in_data[1][0:0];
    assign id2         = in_data[2][2:0];
    assign out_data[0] = od0;
    assign out_data[1] = {7'd0, od1};
    assign out_data[2] = {5'd0, od2};

    xor_descrambler #(.WIDTH(8), .LFSR_LEN(7), .TAP(6)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_data(in_data[0]),
        .i_in_valid(in_valid), .o_in_ready(in_ready[0]), .o_out_data(od0),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready), .o_locked(locked[0])
    );
    xor_descrambler #(.WIDTH(1), .LFSR_LEN(7), .TAP(6)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_data(id1),
        .i_in_valid(in_valid), .o_in_ready(in_ready[1]), .o_out_data(od1),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready), .o_locked(locked[1])
    );
    xor_descrambler #(.WIDTH(3), .LFSR_LEN(7), .TAP(6)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_data(id2),
        .i_in_valid(in_valid), .o_in_ready(in_ready[2]), .o_out_data(od2),
        .o_out_valid(out_valid[2]), .i_out_ready(out_ready), .o_locked(locked[2])
    );

    function automatic int lane_w(int k);
        return (k == 0) ? 8 : (k == 1) ? 1 : 3;
    endfunction

    // Model: history of received scrambled bits since reset/flush; missing history reads as 0.
    bit            hist [NL][$];
    logic [NL-1:0] mv = '0;
    logic [7:0]    md [NL];

    always @(posedge clk) begin
        logic       acc;
        logic [7:0] w;
        int         n;
        bit         b, t1, t2;
        for (int k = 0; k < NL; k++) begin
            if (rst) begin
                hist[k].delete();
                mv[k] = 1'b0;
                md[k] = '0;
            end else begin
                acc = in_valid && !flush && (!mv[k] || out_ready);
                if (flush) hist[k].delete();
                if (acc) begin
                    w = '0;
                    for (int i = 0; i < lane_w(k); i++) begin
                        n    = hist[k].size();
                        b    = in_data[k][i];
                        t1   = (n >= T) ? hist[k][n-T] : 1'b0;
                        t2   = (n >= L) ? hist[k][n-L] : 1'b0;
                        w[i] = b ^ t1 ^ t2;
                        hist[k].push_back(b);
                        if (hist[k].size() > 32) void'(hist[k].pop_front());
                    end
                    md[k] = w;
                    mv[k] = 1'b1;
                end else if (mv[k] && out_ready) begin
                    mv[k] = 1'b0;
                end
            end
        end
    end

    // Literal expectations set by the stimulus for the next falling edge.
    logic [3:0] lit_mask [NL];
    logic [7:0] lit_data [NL];
    logic       lit_v [NL];
    logic       lit_l [NL];
    logic       lit_r [NL];

    int errs   = 0;
    int checks = 0;

    task automatic chk(string nm, int k, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            if (errs <= 30)
                $display("FAIL %s lane%0d t=%0t: got %h, want %h", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic exp_rdy;
        for (int k = 0; k < NL; k++) begin
            exp_rdy = !flush && (!mv[k] || out_ready);
            chk("out_valid", k, {7'd0, out_valid[k]}, {7'd0, mv[k]});
            chk("out_data", k, out_data[k], md[k]);
            chk("locked", k, {7'd0, locked[k]}, {7'd0, hist[k].size() >= L});
            chk("in_ready", k, {7'd0, in_ready[k]}, {7'd0, exp_rdy});
            if (lit_mask[k][0]) chk("lit_data", k, out_data[k], lit_data[k]);
            if (lit_mask[k][1]) chk("lit_valid", k, {7'd0, out_valid[k]}, {7'd0, lit_v[k]});
            if (lit_mask[k][2]) chk("lit_locked", k, {7'd0, locked[k]}, {7'd0, lit_l[k]});
            if (lit_mask[k][3]) chk("lit_ready", k, {7'd0, in_ready[k]}, {7'd0, lit_r[k]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
        for (int k = 0; k < NL; k++) lit_mask[k] = '0;
    endtask

    task automatic want(int k, logic [3:0] m, logic [7:0] d, logic v, logic l, logic r);
        lit_mask[k] = m;
        lit_data[k] = d;
        lit_v[k]    = v;
        lit_l[k]    = l;
        lit_r[k]    = r;
    endtask

    task automatic set_all(logic [7:0] d);
        for (int k = 0; k < NL; k++) in_data[k] = d;
    endtask

    task automatic send(logic [7:0] d);
        set_all(d);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst      = 1'b0;
    endtask

    logic [6:0] sc [NL];
    logic [7:0] src, scr;
    bit         s;

    initial begin
        for (int k = 0; k < NL; k++) begin
            lit_mask[k] = '0;
            md[k]       = '0;
        end
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_all(8'hFF);

        // Reset held two cycles with traffic present
        step();
        step();
        want(0, MD | MV | ML, 8'h00, 1'b0, 1'b0, 1'b0);
        settle();
        rst      = 1'b0;
        in_valid = 1'b0;
        want(0, MR, 8'h00, 1'b0, 1'b0, 1'b1);
        settle();

        // Single beat from zero state
        send(8'h01);
        want(0, MD | MV | ML, 8'hC1, 1'b1, 1'b1, 1'b0);
        want(2, MD, 8'h01, 1'b0, 1'b0, 1'b0);
        settle();

        // State carried across beats
        do_reset();
        send(8'h80);
        want(0, MD | MV, 8'h80, 1'b1, 1'b0, 1'b0);
        settle();
        send(8'h00);
        want(0, MD | MV, 8'h60, 1'b1, 1'b0, 1'b0);
        settle();

        // Backpressure: 80,00,01,80 -> 80,60,C1,80
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_all(8'h80);
        step();
        out_ready = 1'b0;
        set_all(8'h00);
        for (int j = 0; j < 3; j++) begin
            want(0, MD | MV | MR, 8'h80, 1'b1, 1'b0, 1'b0);
            settle();
        end
        out_ready = 1'b1;
        step();
        set_all(8'h01);
        want(0, MD | MV, 8'h60, 1'b1, 1'b0, 1'b0);
        settle();
        step();
        set_all(8'h80);
        want(0, MD | MV, 8'hC1, 1'b1, 1'b0, 1'b0);
        settle();
        step();
        in_valid = 1'b0;
        want(0, MD | MV, 8'h80, 1'b1, 1'b0, 1'b0);
        settle();

        // Flush together with a valid beat
        do_reset();
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            set_all(8'($urandom));
            step();
        end
        flush = 1'b1;
        set_all(8'($urandom));
        want(0, MR, 8'h00, 1'b0, 1'b0, 1'b0);
        settle();
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        want(0, MV | ML, 8'h00, 1'b0, 1'b0, 1'b0);
        settle();
        send(8'h01);
        want(0, MD | MV | ML, 8'hC1, 1'b1, 1'b1, 1'b0);
        settle();

        // Loopback through a reference x^7+x^6+1 scrambler with nonzero start state
        do_reset();
        for (int k = 0; k < NL; k++) sc[k] = 7'h5A;
        for (int n = 0; n < 256; n++) begin
            for (int k = 0; k < NL; k++) begin
                src = 8'($urandom) & 8'((1 << lane_w(k)) - 1);
                scr = '0;
                for (int i = 0; i < lane_w(k); i++) begin
                    s      = src[i] ^ sc[k][T-1] ^ sc[k][L-1];
                    scr[i] = s;
                    sc[k]  = {sc[k][5:0], s};
                end
                in_data[k] = scr;
                lit_data[k] = src;
            end
            in_valid = 1'b1;
            step();
            for (int k = 0; k < NL; k++) begin
                lit_mask[k] = '0;
                if (n * lane_w(k) >= L) lit_mask[k] = lit_mask[k] | MD;
                if (n < 10) begin
                    lit_mask[k] = lit_mask[k] | ML;
                    lit_l[k]    = ((n + 1) * lane_w(k) >= L);
                end
            end
            settle();
        end
        in_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
